// File: rtl/pa_lsu_sram32x4_ctrl.sv
// LSU-side controller for a 32x4 single-port SRAM: power-on/clear init sweep,
// then single-cycle masked writes and 1-cycle-latency reads.
module pa_lsu_sram32x4_ctrl #(
  parameter logic [3:0] INIT_VAL = 4'b0000
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       clr_req,
  input  logic       req_vld,
  input  logic       req_wr,
  input  logic [4:0] req_addr,
  input  logic [3:0] req_wdata,
  input  logic [3:0] req_wmask,
  output logic       req_rdy,
  output logic       rdata_vld,
  output logic [3:0] rdata,
  output logic       init_done,
  output logic [4:0] sram_a,
  output logic       sram_cen,
  output logic       sram_gwen,
  output logic [3:0] sram_wen,
  output logic [4:0] sram_a_unused_c,
  output logic [3:0] sram_d,
  input  logic [3:0] sram_q
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(31);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          rd_pend;
  logic          rd_acc;
  logic [DW-1:0] rdata_q;

  // State register, sweep counter and read-return pipeline
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_pend <= rd_acc;
      if (rd_pend) begin
        rdata_q <= sram_q;
      end
    end
  end

  // Next state and SRAM-side controls; request accept is same-cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_rdy   = 1'b0;
    rd_acc    = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (state)
      IDLE: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
      INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt;
        sram_d    = INIT_VAL;
        // A clear mid-sweep restarts from entry 0
        if (clr_req) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_ADDR) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      RUN: begin
        req_rdy = ~clr_req;
        if (clr_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end else if (req_vld) begin
          sram_a = req_addr;
          if (req_wr) begin
            // Fully masked write is accepted but touches nothing
            if (req_wmask != '0) begin
              sram_cen  = 1'b0;
              sram_gwen = 1'b0;
              sram_wen  = ~req_wmask;
              sram_d    = req_wdata;
            end
          end else begin
            sram_cen = 1'b0;
            rd_acc   = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sram_a_unused_c = '0;
  assign init_done = (state == RUN);
  assign rdata_vld = rd_pend;
  // sram_q is only valid in the cycle after the access, so pass it through then
  assign rdata     = rd_pend ? sram_q : rdata_q;

endmodule

// File: tb/tb_pa_lsu_sram32x4_ctrl.sv
// Scoreboarded directed bench for pa_lsu_sram32x4_ctrl with a behavioural
// 32x4 SRAM model; read expectations are queued at issue, checked on rdata_vld.
module tb_pa_lsu_sram32x4_ctrl;

  localparam logic [3:0] IV = 4'b0110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_req, req_vld, req_wr;
  logic [4:0] req_addr;
  logic [3:0] req_wdata, req_wmask;
  logic       req_rdy, rdata_vld, init_done;
  logic [3:0] rdata;
  logic [4:0] sram_a, sram_a_unused_c;
  logic       sram_cen, sram_gwen;
  logic [3:0] sram_wen, sram_d, sram_q;

  logic [3:0] mem [32];
  logic [3:0] exp_q [$];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pa_lsu_sram32x4_ctrl #(.INIT_VAL(IV)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .clr_req(clr_req),
    .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_rdy(req_rdy),
    .rdata_vld(rdata_vld), .rdata(rdata), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_a_unused_c(sram_a_unused_c),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural SRAM: bit-masked write, registered read data
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rdata_vld pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && rdata_vld) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rdata_vld_unexpected: got pulse with rdata %0h expected none at %0t", rdata, $time);
      end else begin
        check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({req_rdy, rdata_vld, init_done, sram_cen, sram_gwen, sram_wen}),
          32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111}));
    check({tag, "_bus"}, 32'({rdata, sram_a, sram_d}), 32'({4'b0000, 5'd0, 4'b0000}));
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] d, input logic [3:0] m,
                          input logic exp_cen, input logic [3:0] exp_wen);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    check("wr_rdy", 32'(req_rdy), 32'(1));
    check("wr_cen", 32'(sram_cen), 32'(exp_cen));
    if (!exp_cen) begin
      check("wr_bus", 32'({sram_gwen, sram_wen, sram_a, sram_d}), 32'({1'b0, exp_wen, a, d}));
    end
    tick();
    idle_req();
  endtask

  task automatic do_read(input logic [4:0] a, input logic [3:0] exp_data, input bit push);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
    #1;
    check("rd_bus", 32'({req_rdy, sram_cen, sram_gwen, sram_wen, sram_a}),
          32'({1'b1, 1'b0, 1'b1, 4'b1111, a}));
    if (push) exp_q.push_back(exp_data);
    tick();
    idle_req();
  endtask

  // Entered at posedge+1 of the first INIT cycle; optional clear at sweep count clr_at
  task automatic sweep_check(input int clr_at);
    int  k = 0;
    bit  restarted = 1'b0;
    while (k < 32) begin
      #1;
      check("sweep_a", 32'(sram_a), 32'(k));
      check("sweep_ctl", 32'({sram_cen, sram_gwen, sram_wen, sram_d, req_rdy, init_done}),
            32'({1'b0, 1'b0, 4'b0000, IV, 1'b0, 1'b0}));
      if (!restarted && k == clr_at) begin
        clr_req = 1'b1;
        restarted = 1'b1;
        k = 0;
      end else begin
        k++;
      end
      tick();
      clr_req = 1'b0;
    end
    #1;
    check("init_done", 32'({init_done, req_rdy}), 32'({1'b1, 1'b1}));
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0;
    idle_req();
    #22;
    check_reset_outputs("reset");

    // Release away from the edge; still IDLE until the first edge
    @(negedge clk);
    rst_n = 1'b1;
    clr_req = 1'b1;
    #1;
    check("idle_after_release", 32'({init_done, req_rdy, sram_cen}), 32'({1'b0, 1'b0, 1'b1}));
    tick();
    clr_req = 1'b0;
    sweep_check(-1);

    // Full and partial masked writes with read-back
    do_write(5'd5, 4'b1010, 4'b1111, 1'b0, 4'b0000);
    do_read(5'd5, 4'b1010, 1'b1);
    do_write(5'd5, 4'b0101, 4'b0011, 1'b0, 4'b1100);
    do_read(5'd5, 4'b1001, 1'b1);
    do_read(5'd9, IV, 1'b1);

    // Boundary addresses, back-to-back reads
    do_write(5'd31, 4'b1111, 4'b1111, 1'b0, 4'b0000);
    do_write(5'd0, 4'b0011, 4'b1111, 1'b0, 4'b0000);
    do_read(5'd31, 4'b1111, 1'b1);
    do_read(5'd0, 4'b0011, 1'b1);
    do_read(5'd31, 4'b1111, 1'b1);

    // Read then write same address returns pre-write data
    do_read(5'd5, 4'b1001, 1'b1);
    do_write(5'd5, 4'b0000, 4'b1111, 1'b0, 4'b0000);
    do_read(5'd5, 4'b0000, 1'b1);

    // Fully masked write: accepted, no SRAM access
    do_write(5'd5, 4'b1111, 4'b0000, 1'b1, 4'b1111);
    do_read(5'd5, 4'b0000, 1'b1);
    tick();
    check("run_idle", 32'({sram_cen, sram_gwen, rdata_vld, rdata}), 32'({1'b1, 1'b1, 1'b0, 4'b0000}));

    // Clear together with a read: refused, sweep restarts, pending read still returns
    do_read(5'd31, 4'b1111, 1'b1);
    clr_req = 1'b1; req_vld = 1'b1; req_wr = 1'b0; req_addr = 5'd7;
    #1;
    check("clr_rd_rdy", 32'({req_rdy, sram_cen}), 32'({1'b0, 1'b1}));
    tick();
    clr_req = 1'b0;
    idle_req();
    sweep_check(17);

    // Sweep rewrote INIT_VAL everywhere
    do_read(5'd5, IV, 1'b1);
    do_read(5'd31, IV, 1'b1);
    tick();
    check("rdata_held", 32'(rdata), 32'(IV));

    // Reset in the middle of a read stream
    do_write(5'd0, 4'b1100, 4'b1111, 1'b0, 4'b0000);
    do_read(5'd31, IV, 1'b1);
    do_read(5'd0, 4'b1100, 1'b0);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 5'd31;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    idle_req();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_reset", 32'({init_done, rdata_vld, rdata}), 32'({1'b0, 1'b0, 4'b0000}));
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
